async_fifo_prog: RTL

//   Next-generation dual-clock FIFO. Passes DATA_WIDTH words from the wr_clk domain to the rd_clk domain.

---
 rtl/async_fifo_pkg.sv | 25 ++
 rtl/dual_port_ram.sv | 22 ++
 rtl/fifo_gray_ptr.sv | 34 +++
 rtl/shift_register.sv | 21 ++
 rtl/async_fifo_prog.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: Gray-code conversion and sizing helpers shared by the dual-clock FIFO.
//   level_w(depth)          width of a pointer or fill level for a FIFO of the given depth
//   gray_conv#(W)::bin2gray binary -> reflected Gray, W bits
//   gray_conv#(W)::gray2bin reflected Gray -> binary, W bits
package async_fifo_pkg;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Parameterised holder so both conversions work at any pointer width.
    virtual class gray_conv #(parameter int W = 5);
        static function logic [W-1:0] bin2gray(input logic [W-1:0] b);
            return b ^ (b >> 1);
        endfunction
        static function logic [W-1:0] gray2bin(input logic [W-1:0] g);
            logic [W-1:0] b;
            b[W-1] = g[W-1];
            for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
            return b;
        endfunction
    endclass

endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: storage array with a clocked write port and an asynchronous read port.
//   wr_clk, wr_en, wr_addr, wr_data   write port, written on wr_clk when wr_en
//   rd_addr, rd_data                  combinational read port
// Contents are never reset.
module dual_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge wr_clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fifo_gray_ptr.sv
// fifo_gray_ptr: W-bit binary pointer with a registered Gray copy; one per clock domain.
//   clk, reset           clock and asynchronous active-high reset (pointer restarts at 0)
//   inc                  advance by one this edge (wraps mod 2**W)
//   addr                 memory address (pointer without its wrap bit)
//   gray                 registered Gray form, safe to synchronize into the other domain
//   next_bin, next_gray  value the pointer takes at the coming edge
module fifo_gray_ptr
    import async_fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-2:0] addr,
    output logic [W-1:0] gray,
    output logic [W-1:0] next_bin,
    output logic [W-1:0] next_gray
);
    logic [W-1:0] bin;

    assign next_bin  = bin + W'(inc);
    assign next_gray = gray_conv#(W)::bin2gray(next_bin);
    assign addr      = bin[W-2:0];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= next_bin;
            gray <= next_gray;
        end
endmodule

// File: rtl/shift_register.sv
// shift_register: chain of NUM_OF_STAGES flops, used as a multi-bit synchronizer for Gray pointers.
//   clk, reset   clock and asynchronous active-high reset (clears every stage)
//   d            WIDTH-bit input captured each clk edge
//   q            d delayed by NUM_OF_STAGES clk edges
module shift_register #(
    parameter int WIDTH         = 1,
    parameter int NUM_OF_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [NUM_OF_STAGES-1:0][WIDTH-1:0] stages;

    always_ff @(posedge clk or posedge reset)
        if (reset) stages <= '0;
        else       stages <= {stages[NUM_OF_STAGES-2:0], d};

    assign q = stages[NUM_OF_STAGES-1];
endmodule

// File: rtl/async_fifo_prog.sv
// async_fifo_prog: dual-clock FIFO with fill levels, programmable thresholds and sticky error flags.
//   reset             asynchronous active-high, clears both domains
//   wr_clk domain     wr_en, wr_data, af_thresh -> wr_full, wr_almost_full, wr_level, wr_overflow
//   rd_clk domain     rd_en, ae_thresh -> rd_data, rd_valid, rd_empty, rd_almost_empty, rd_level, rd_underflow
//   FWFT=0            rd_data/rd_valid register one rd_clk after an accepted rd_en
//   FWFT=1            rd_data shows the head word whenever rd_valid (= !rd_empty)
module async_fifo_prog
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 0,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  reset,
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W:0]       af_thresh,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic [ADDR_W:0]       wr_level,
    output logic                  wr_overflow,
    input  logic                  rd_en,
    input  logic [ADDR_W:0]       ae_thresh,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_W:0]       rd_level,
    output logic                  rd_underflow
);
    localparam int PW = level_w(DEPTH);

    logic                  w_inc, r_inc;
    logic [ADDR_W-1:0]     waddr, raddr;
    logic [PW-1:0]         wgray, wbin_n, wgray_n, rq, rq_bin, wr_level_n;
    logic [PW-1:0]         rgray, rbin_n, rgray_n, wq, wq_bin, rd_level_n;
    logic [DATA_WIDTH-1:0] ram_q;

    // ---------------- write domain ----------------
    assign w_inc = wr_en & ~wr_full;

    fifo_gray_ptr #(.W(PW)) u_wptr (
        .clk       (wr_clk),
        .reset     (reset),
        .inc       (w_inc),
        .addr      (waddr),
        .gray      (wgray),
        .next_bin  (wbin_n),
        .next_gray (wgray_n)
    );

    shift_register #(.WIDTH(PW), .NUM_OF_STAGES(SYNC_STAGES)) u_rq_sync (
        .clk   (wr_clk),
        .reset (reset),
        .d     (rgray),
        .q     (rq)
    );

    // The synchronized read pointer lags, so this level can only over-estimate.
    assign rq_bin     = gray_conv#(PW)::gray2bin(rq);
    assign wr_level_n = wbin_n - rq_bin;

    always_ff @(posedge wr_clk or posedge reset)
        if (reset) begin
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            // Full when the writer is one lap ahead: top two Gray bits inverted, rest equal.
            wr_full        <= wgray_n == {~rq[PW-1:PW-2], rq[PW-3:0]};
            wr_almost_full <= wr_level_n >= af_thresh;
            wr_level       <= wr_level_n;
            wr_overflow    <= wr_overflow | (wr_en & wr_full);
        end

    dual_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_W)) u_ram (
        .wr_clk  (wr_clk),
        .wr_en   (w_inc),
        .wr_addr (waddr),
        .wr_data (wr_data),
        .rd_addr (raddr),
        .rd_data (ram_q)
    );

    // ---------------- read domain ----------------
    assign r_inc = rd_en & ~rd_empty;

    fifo_gray_ptr #(.W(PW)) u_rptr (
        .clk       (rd_clk),
        .reset     (reset),
        .inc       (r_inc),
        .addr      (raddr),
        .gray      (rgray),
        .next_bin  (rbin_n),
        .next_gray (rgray_n)
    );

    shift_register #(.WIDTH(PW), .NUM_OF_STAGES(SYNC_STAGES)) u_wq_sync (
        .clk   (rd_clk),
        .reset (reset),
        .d     (wgray),
        .q     (wq)
    );

    // The synchronized write pointer lags, so this level can only under-estimate.
    assign wq_bin     = gray_conv#(PW)::gray2bin(wq);
    assign rd_level_n = wq_bin - rbin_n;

    always_ff @(posedge rd_clk or posedge reset)
        if (reset) begin
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_level        <= '0;
            rd_underflow    <= 1'b0;
        end else begin
            rd_empty        <= rgray_n == wq;
            rd_almost_empty <= rd_level_n <= ae_thresh;
            rd_level        <= rd_level_n;
            rd_underflow    <= rd_underflow | (rd_en & rd_empty);
        end

    if (FWFT != 0) begin : g_fwft
        // Head word is read straight from the array; blanked while empty so stale contents never show.
        assign rd_valid = ~rd_empty;
        assign rd_data  = rd_empty ? '0 : ram_q;
    end else begin : g_std
        always_ff @(posedge rd_clk or posedge reset)
            if (reset) begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end else begin
                rd_valid <= r_inc;
                if (r_inc) rd_data <= ram_q;
            end
    end
endmodule
